// File: rtl/cmp_pkg.sv
// Shared types and elaboration-time helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter width that can hold every value 0..NCHUNK.
  function automatic int cw_of(input int width, input int chunk);
    return clog2(width / chunk + 1);
  endfunction

  localparam int NCHUNK = nchunk_of(16, 2);
  localparam int CW     = cw_of(16, 2);

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Start/busy/done request and result bundle of the sequential magnitude comparator.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [CW-1:0]    chunks;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gt, lt, eq, chunks
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gt, lt, eq, chunks
  );
endinterface

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational greater/less/equal cell for one CHUNK-bit slice pair.
module chunk_cmp #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             g,
  output logic             l,
  output logic             e
);

  assign g = (x > y);
  assign l = (x < y);
  assign e = (x == y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator: one CHUNK-bit slice per clock,
// early exit on the first differing slice.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_mag_comparator_if.slave bus
);

  localparam int NCH = nchunk_of(WIDTH, CHUNK);
  localparam int CWL = cw_of(WIDTH, CHUNK);
  localparam int IW  = (NCH > 1) ? clog2(NCH) : 1;

  state_e           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [IW-1:0]    idx;
  logic             cg;
  logic             cl;
  logic             ce;

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x (ra[int'(idx)*CHUNK +: CHUNK]),
    .y (rb[int'(idx)*CHUNK +: CHUNK]),
    .g (cg),
    .l (cl),
    .e (ce)
  );

  // NOTE: non-blocking assignments so every register sees pre-edge values; the
  // result registers read cg/cl/ce, which depend on idx updated in this same block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      // NOTE: operand registers are ordinary flops, not a RAM, so they are reset too.
      ra          <= '0;
      rb          <= '0;
      idx         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.gt      <= 1'b0;
      bus.lt      <= 1'b0;
      bus.eq      <= 1'b0;
      bus.chunks  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            ra       <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
            rb       <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
            idx      <= IW'(NCH - 1);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cg || cl || idx == '0) begin
            bus.gt     <= cg;
            bus.lt     <= cl;
            bus.eq     <= ce;
            bus.chunks <= CWL'(NCH - int'(idx));
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Randomized bench for seq_mag_comparator (16/2 and 8/8 configurations)
// against an arithmetic reference model.
module tb_seq_mag_comparator;
  import cmp_pkg::*;

  localparam int CW16 = cw_of(16, 2);
  localparam int CW8  = cw_of(8, 8);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_mag_comparator_if #(.WIDTH(16), .CW(CW16)) if16 ();
  seq_mag_comparator_if #(.WIDTH(8),  .CW(CW8))  if8 ();

  seq_mag_comparator #(.WIDTH(16), .CHUNK(2)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  seq_mag_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  // sel picks which instance receives start and is observed.
  bit          sel;
  logic        start_d;
  logic        sm_d;
  logic [15:0] a_d;
  logic [15:0] b_d;

  assign if16.start       = start_d & ~sel;
  assign if16.signed_mode = sm_d;
  assign if16.a           = a_d;
  assign if16.b           = b_d;
  assign if8.start        = start_d & sel;
  assign if8.signed_mode  = sm_d;
  assign if8.a            = a_d[7:0];
  assign if8.b            = b_d[7:0];

  logic       o_busy, o_done, o_gt, o_lt, o_eq;
  logic [3:0] o_chunks;

  assign o_busy   = sel ? if8.busy : if16.busy;
  assign o_done   = sel ? if8.done : if16.done;
  assign o_gt     = sel ? if8.gt   : if16.gt;
  assign o_lt     = sel ? if8.lt   : if16.lt;
  assign o_eq     = sel ? if8.eq   : if16.eq;
  assign o_chunks = sel ? 4'(if8.chunks) : 4'(if16.chunks);

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer compare of the operands' values, and chunk count from the
  // highest differing bit position.
  function automatic void model(input bit sm, input logic [15:0] a, input logic [15:0] b,
                                input int w, input int c, output int rel, output int nch);
    longint va, vb;
    logic [15:0] d;
    int p;
    va = longint'(a) & ((longint'(1) << w) - 1);
    vb = longint'(b) & ((longint'(1) << w) - 1);
    if (sm && a[w-1]) va -= (longint'(1) << w);
    if (sm && b[w-1]) vb -= (longint'(1) << w);
    rel = (va > vb) ? 1 : (va < vb) ? -1 : 0;
    d = a ^ b;
    p = -1;
    for (int i = 0; i < w; i++) if (d[i]) p = i;
    nch = (p < 0) ? w / c : (w - 1 - p) / c + 1;
  endfunction

  task automatic do_cmp(input bit sm, input logic [15:0] a, input logic [15:0] b,
                        input bit disturb, input string tag);
    int w, c, rel, nch, k;
    bit seen;
    logic gt_s, lt_s, eq_s;
    w = sel ? 8 : 16;
    c = sel ? 8 : 2;
    model(sm, a, b, w, c, rel, nch);
    @(negedge clk);
    a_d = a; b_d = b; sm_d = sm; start_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (disturb) begin
      a_d = 16'hFFFF; sm_d = ~sm; start_d = 1'b1;
    end else begin
      start_d = 1'b0;
    end
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      k++;
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      check({tag, " busy_run"}, 32'(o_busy), 32'd1);
      @(negedge clk);
      if (disturb) begin
        a_d = 16'($urandom); start_d = 1'b1;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(nch));
    check({tag, " gt"}, 32'(o_gt), 32'(rel > 0));
    check({tag, " lt"}, 32'(o_lt), 32'(rel < 0));
    check({tag, " eq"}, 32'(o_eq), 32'(rel == 0));
    check({tag, " chunks"}, 32'(o_chunks), 32'(nch));
    gt_s = o_gt; lt_s = o_lt; eq_s = o_eq;
    @(negedge clk);
    start_d = 1'b0;
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(o_done), 32'd0);
    check({tag, " busy_idle"}, 32'(o_busy), 32'd0);
    check({tag, " hold"}, {29'd0, o_gt, o_lt, o_eq}, {29'd0, gt_s, lt_s, eq_s});
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"},   32'(if16.busy | if8.busy), 32'd0);
    check({tag, " done"},   32'(if16.done | if8.done), 32'd0);
    check({tag, " gtlteq"}, {29'd0, if16.gt | if8.gt, if16.lt | if8.lt, if16.eq | if8.eq}, 32'd0);
    check({tag, " chunks"}, 32'(if16.chunks) | 32'(if8.chunks), 32'd0);
  endtask

  initial begin
    int gap;
    bit seen;
    logic [15:0] ra, rb;
    bit rsm;

    sel = 1'b0; start_d = 1'b0; sm_d = 1'b0; a_d = '0; b_d = '0;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_release");

    do_cmp(1'b0, 16'h8000, 16'h7FFF, 1'b0, "u_8000_7fff");
    do_cmp(1'b1, 16'h8000, 16'h7FFF, 1'b0, "s_8000_7fff");
    do_cmp(1'b1, 16'h7FFF, 16'h8000, 1'b0, "s_7fff_8000");
    do_cmp(1'b1, 16'hFFFF, 16'h0001, 1'b0, "s_ffff_0001");
    do_cmp(1'b0, 16'h1234, 16'h1234, 1'b0, "u_eq_1234");
    do_cmp(1'b0, 16'h1235, 16'h1234, 1'b0, "u_1235_1234");
    do_cmp(1'b0, 16'h0001, 16'h0002, 1'b1, "disturb_run");

    // start held high: done pulses are three edges apart (DONE, IDLE, RUN).
    @(negedge clk);
    a_d = 16'h8000; b_d = 16'h7FFF; sm_d = 1'b0; start_d = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_done) begin seen = 1'b1; break; end
    end
    check("b2b first_done", 32'(seen), 32'd1);
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      gap++;
      if (o_done) begin seen = 1'b1; break; end
    end
    check("b2b second_done", 32'(seen), 32'd1);
    check("b2b gap", 32'(gap), 32'd3);
    @(negedge clk);
    start_d = 1'b0;
    @(posedge clk); #1;
    check("b2b idle", 32'(o_busy), 32'd0);

    // Reset on the third RUN cycle of an eq compare.
    do_cmp(1'b0, 16'h0100, 16'h0200, 1'b0, "pre_reset");
    @(negedge clk);
    a_d = 16'h1234; b_d = 16'h1234; sm_d = 1'b0; start_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_d = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_mid busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_done) seen = 1'b1;
    end
    check("rst_mid no_done", 32'(seen), 32'd0);
    do_cmp(1'b0, 16'h4321, 16'h4320, 1'b0, "post_reset");

    for (int n = 0; n < 1000; n++) begin
      rsm = 1'($urandom);
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      do_cmp(rsm, ra, rb, 1'b0, "rand16");
    end

    sel = 1'b1;
    do_cmp(1'b0, 16'h0010, 16'h0010, 1'b0, "w8_eq_10");
    do_cmp(1'b1, 16'h0080, 16'h007F, 1'b0, "w8_s_80_7f");
    for (int n = 0; n < 50; n++) begin
      rsm = 1'($urandom);
      ra = 16'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom_range(0, 255));
      do_cmp(rsm, ra, rb, 1'b0, "rand8");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
